// File: rtl/symbol_count_feeder_pkg.sv
// Shared Huffman sort-stage definitions: default widths, the saturation
// ceiling for the default count width, and the feeder state encoding.
package symbol_count_feeder_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_TOTAL_SYMBOLS = 10;
    localparam int DEF_ADDR_WIDTH    = 4;

    // Largest value a default-width count can hold before saturating.
    localparam int COUNT_MAX = (1 << DEF_DATA_WIDTH) - 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_COUNT = 2'd1,
        ST_FEED  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/symbol_count_feeder_sat_counter.sv
// Saturating up-counter with synchronous clear. It exposes the next-cycle value
// so the feeder can capture a count in the same edge that increments it.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_next_o,
    output logic             sat_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign sat_o        = (count_q == {WIDTH{1'b1}});
    assign count_next_o = count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !sat_o) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the count bank is plain flops, not RAM, so it is reset like any other state.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/symbol_count_feeder.sv
// Huffman sort front end: counts symbol frequencies over a frame, then streams
// the (count, address) pairs into the insertion-sort cell chain.
module symbol_count_feeder
    import symbol_count_feeder_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int TOTAL_SYMBOLS = DEF_TOTAL_SYMBOLS,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sym_valid,
    input  logic [ADDR_WIDTH-1:0] sym,
    input  logic                  sym_last,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] sort_din,
    output logic [ADDR_WIDTH-1:0] sort_addr,
    output logic                  sort_ena,
    output logic                  sort_done,
    output logic                  ovf
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL_SYMBOLS - 1);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   index_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   sort_din_q;
    logic [ADDR_WIDTH-1:0]   sort_addr_q;
    logic                    sort_ena_q;
    logic                    sort_done_q;
    logic                    ovf_q;

    logic                    count_en;
    logic                    clr;
    logic [TOTAL_SYMBOLS-1:0] inc;
    logic [TOTAL_SYMBOLS-1:0] sat;
    logic [DATA_WIDTH-1:0]   cnt_next [TOTAL_SYMBOLS];
    logic                    ovf_hit;
    logic [ADDR_WIDTH-1:0]   feed_idx;

    // start takes priority over a symbol arriving in the same cycle.
    assign count_en = (state_q == ST_COUNT) && sym_valid && !start;
    assign clr      = (state_q == ST_CLEAR);
    assign ovf_hit  = |(inc & sat);

    // One saturating counter per symbol; out-of-range symbols match none of them.
    for (genvar i = 0; i < TOTAL_SYMBOLS; i++) begin : g_cnt
        assign inc[i] = count_en && (sym == ADDR_WIDTH'(i));

        sat_counter #(
            .WIDTH (DATA_WIDTH)
        ) u_cnt (
            .clk          (clk),
            .rst_n        (rst_n),
            .clr_i        (clr),
            .inc_i        (inc[i]),
            .count_next_o (cnt_next[i]),
            .sat_o        (sat[i])
        );
    end

    // Address to emit at this edge: 0 when leaving COUNT, else the one after the shown pair.
    always_comb begin
        feed_idx = '0;
        if (state_q == ST_FEED) begin
            feed_idx = index_q + ADDR_WIDTH'(1);
        end
    end

    // Frame control FSM with registered outputs; index_q tracks the address on sort_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            index_q     <= '0;
            busy_q      <= 1'b1;
            sort_din_q  <= '0;
            sort_addr_q <= '0;
            sort_ena_q  <= 1'b0;
            sort_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (start) begin
            state_q     <= ST_CLEAR;
            index_q     <= '0;
            busy_q      <= 1'b1;
            sort_ena_q  <= 1'b0;
            sort_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    state_q <= ST_COUNT;
                    busy_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                end
                ST_COUNT: begin
                    if (ovf_hit) begin
                        ovf_q <= 1'b1;
                    end
                    if (sym_valid && sym_last) begin
                        state_q     <= ST_FEED;
                        index_q     <= feed_idx;
                        busy_q      <= 1'b1;
                        sort_din_q  <= cnt_next[feed_idx];
                        sort_addr_q <= feed_idx;
                        sort_ena_q  <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (index_q == LAST_IDX) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        sort_ena_q  <= 1'b0;
                        sort_done_q <= 1'b1;
                    end else begin
                        index_q     <= feed_idx;
                        sort_din_q  <= cnt_next[feed_idx];
                        sort_addr_q <= feed_idx;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign sort_din  = sort_din_q;
    assign sort_addr = sort_addr_q;
    assign sort_ena  = sort_ena_q;
    assign sort_done = sort_done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_symbol_count_feeder.sv
// Directed bench: a 16-bit and a 4-bit feeder share one stimulus stream and are
// checked against hand-computed per-frame count tables.
module tb_symbol_count_feeder;

    localparam int NSYM = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sym_valid;
    logic [3:0]  sym;
    logic        sym_last;

    logic        busy, sort_ena, sort_done, ovf;
    logic [15:0] sort_din;
    logic [3:0]  sort_addr;

    logic        busy4, sort_ena4, sort_done4, ovf4;
    logic [3:0]  sort_din4;
    logic [3:0]  sort_addr4;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int exp_cnt [NSYM];

    symbol_count_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sym_valid (sym_valid),
        .sym       (sym),
        .sym_last  (sym_last),
        .busy      (busy),
        .sort_din  (sort_din),
        .sort_addr (sort_addr),
        .sort_ena  (sort_ena),
        .sort_done (sort_done),
        .ovf       (ovf)
    );

    symbol_count_feeder #(.DATA_WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sym_valid (sym_valid),
        .sym       (sym),
        .sym_last  (sym_last),
        .busy      (busy4),
        .sort_din  (sort_din4),
        .sort_addr (sort_addr4),
        .sort_ena  (sort_ena4),
        .sort_done (sort_done4),
        .ovf       (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < NSYM; i++) exp_cnt[i] = 0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clear_busy", busy, 1);
        tick();
        check("count_busy", busy, 0);
    endtask

    task automatic send(input int s, input bit last);
        sym_valid = 1'b1;
        sym       = 4'(s);
        sym_last  = last;
        tick();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    // Called right after the sym_last edge: expects ten ascending pairs then DONE.
    task automatic check_feed(input string name);
        int e4;
        for (int i = 0; i < NSYM; i++) begin
            e4 = (exp_cnt[i] > 15) ? 15 : exp_cnt[i];
            check($sformatf("%s_ena%0d", name, i), sort_ena, 1);
            check($sformatf("%s_addr%0d", name, i), sort_addr, i);
            check($sformatf("%s_din%0d", name, i), sort_din, exp_cnt[i]);
            check($sformatf("%s_din4_%0d", name, i), sort_din4, e4);
            check($sformatf("%s_busy%0d", name, i), busy, 1);
            check($sformatf("%s_ndone%0d", name, i), sort_done, 0);
            tick();
        end
        check({name, "_ena_off"}, sort_ena, 0);
        check({name, "_done"}, sort_done, 1);
        check({name, "_busy_off"}, busy, 0);
        check({name, "_hold_addr"}, sort_addr, NSYM - 1);
        check({name, "_hold_din"}, sort_din, exp_cnt[NSYM - 1]);
        tick();
        check({name, "_done_level"}, sort_done, 1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_busy"}, busy, 1);
        check({name, "_din"}, sort_din, 0);
        check({name, "_addr"}, sort_addr, 0);
        check({name, "_ena"}, sort_ena, 0);
        check({name, "_done"}, sort_done, 0);
        check({name, "_ovf"}, ovf, 0);
        check({name, "_ovf4"}, ovf4, 0);
        check({name, "_din4"}, sort_din4, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sym_valid = 1'b0; sym = '0; sym_last = 1'b0;
        #12;
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Basic frame 3,3,1,9(last).
        start_frame();
        send(3, 0); send(3, 0); send(1, 0); send(9, 1);
        clear_exp(); exp_cnt[1] = 1; exp_cnt[3] = 2; exp_cnt[9] = 1;
        check_feed("basic");

        // Out-of-range symbols dropped, sym_last on 15 still honoured.
        start_frame();
        send(12, 0); send(4, 0); send(15, 1);
        clear_exp(); exp_cnt[4] = 1;
        check_feed("oor");

        // Symbol 2 seventeen times: 4-bit counter saturates at 15.
        start_frame();
        for (int i = 0; i < 16; i++) send(2, 0);
        send(2, 1);
        clear_exp(); exp_cnt[2] = 17;
        check("sat_ovf4", ovf4, 1);
        check("sat_ovf16", ovf, 0);
        check_feed("sat");
        check("sat_ovf4_sticky", ovf4, 1);

        // Abort at the fourth FEED cycle.
        start_frame();
        check("abort_ovf4_cleared", ovf4, 0);
        send(7, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_addr%0d", i), sort_addr, i);
            if (i < 3) tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_ena_off", sort_ena, 0);
        check("abort_no_done", sort_done, 0);
        check("abort_clear_busy", busy, 1);
        tick();
        check("abort_count_busy", busy, 0);
        check("abort_no_done2", sort_done, 0);
        send(11, 1);
        clear_exp();
        check_feed("post_abort");

        // Asynchronous reset in the middle of COUNT.
        start_frame();
        for (int i = 0; i < 16; i++) send(2, 0);
        check("pre_rst_ovf4", ovf4, 1);
        check("pre_rst_busy", busy, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #10;
        rst_n = 1'b1;
        start_frame();
        send(8, 1);
        clear_exp(); exp_cnt[8] = 1;
        check_feed("post_rst");

        // start together with a valid symbol: the symbol is dropped.
        start_frame();
        send(5, 0);
        start = 1'b1; sym_valid = 1'b1; sym = 4'd5;
        tick();
        start = 1'b0; sym_valid = 1'b0;
        tick();
        send(6, 1);
        clear_exp(); exp_cnt[6] = 1;
        check_feed("start_wins");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
